// File: rtl/write_ddr_packer_if.sv
// Sample-in / packed-word-out handshake bundle for the DDR write packer.
// The slave modport is the packer; master is the side that feeds samples and takes words.
interface write_ddr_packer_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 256
);
  logic                   s_valid;
  logic                   s_ready;
  logic [IN_WIDTH-1:0]    s_data;
  logic                   flush;
  logic                   m_valid;
  logic                   m_ready;
  logic [OUT_WIDTH-1:0]   m_data;
  logic [OUT_WIDTH/8-1:0] m_keep;
  logic                   m_last;

  modport master (
    output s_valid, s_data, flush, m_ready,
    input  s_ready, m_valid, m_data, m_keep, m_last
  );

  modport slave (
    input  s_valid, s_data, flush, m_ready,
    output s_ready, m_valid, m_data, m_keep, m_last
  );
endinterface

// File: rtl/write_ddr_packer.sv
// Packs 32-bit samples (lane 0 first) into 256-bit DDR words, groups words into
// bursts with a last flag, and flushes a partial word with byte enables on request.
module write_ddr_packer #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 256,
  parameter int BURST_LEN = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  write_ddr_packer_if.slave    bus,
  output logic                 busy,
  output logic [CNT_WIDTH-1:0] word_cnt
);
  localparam int RATIO      = OUT_WIDTH / IN_WIDTH;
  localparam int LW         = $clog2(RATIO);
  localparam int BW         = $clog2(BURST_LEN);
  localparam int KW         = OUT_WIDTH / 8;
  localparam int LANE_BYTES = IN_WIDTH / 8;

  logic [OUT_WIDTH-1:0] pack;
  logic [LW-1:0]        lane;
  logic [BW-1:0]        burst_cnt;
  logic                 flush_pend;

  logic          free;
  logic          lane_full;
  logic          accept;
  logic          full_load;
  logic          flush_emit;
  logic          burst_end;
  logic [KW-1:0] part_keep;

  assign free        = !bus.m_valid || bus.m_ready;
  assign lane_full   = (lane == LW'(RATIO - 1));
  assign bus.s_ready = !flush_pend && !(lane_full && !free);
  assign accept      = bus.s_valid && bus.s_ready;
  assign full_load   = accept && lane_full;
  assign flush_emit  = flush_pend && (lane != '0) && free;
  assign burst_end   = (burst_cnt == BW'(BURST_LEN - 1));
  assign busy        = (lane != '0) || bus.m_valid || flush_pend;

  always_comb begin
    part_keep = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (i < 32'(lane)) part_keep[i*LANE_BYTES +: LANE_BYTES] = '1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pack        <= '0;
      lane        <= '0;
      burst_cnt   <= '0;
      flush_pend  <= 1'b0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_keep  <= '0;
      bus.m_last  <= 1'b0;
      word_cnt    <= '0;
    end else begin
      if (full_load || flush_emit) begin
        bus.m_valid <= 1'b1;
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end

      if (bus.m_valid && bus.m_ready) word_cnt <= word_cnt + CNT_WIDTH'(1);

      // Flush pending blocks s_ready, so a full-word load and a flush emit never coincide.
      if (full_load) begin
        bus.m_data <= {bus.s_data, pack[OUT_WIDTH-IN_WIDTH-1:0]};
        bus.m_keep <= '1;
        bus.m_last <= burst_end || bus.flush;
        burst_cnt  <= (burst_end || bus.flush) ? '0 : burst_cnt + BW'(1);
        pack       <= '0;
        lane       <= '0;
      end else if (accept) begin
        pack[32'(lane)*IN_WIDTH +: IN_WIDTH] <= bus.s_data;
        lane <= lane + LW'(1);
      end else if (flush_emit) begin
        bus.m_data <= pack;
        bus.m_keep <= part_keep;
        bus.m_last <= 1'b1;
        burst_cnt  <= '0;
        pack       <= '0;
        lane       <= '0;
      end

      // A flush that completes a full word closes the burst directly and leaves nothing pending.
      if (flush_pend) begin
        if (lane == '0) begin
          flush_pend <= 1'b0;
          burst_cnt  <= '0;
        end else if (flush_emit) begin
          flush_pend <= 1'b0;
        end
      end else if (bus.flush && !full_load) begin
        flush_pend <= 1'b1;
      end
    end
  end
endmodule

// File: doc/write_ddr_packer.md
Name: write_ddr_packer

Overview:
Write-path gearbox that packs 32-bit audio samples into 256-bit words for the DDR write channel. It is the counterpart of the 256-to-32 read-side unpacking FIFO. Sample order is lane 0 first, so a word written by this block and read back through the read path returns the samples in their original order. It also groups output words into DDR bursts with a last flag, and it can flush a partial word using byte enables.

Parameters:
IN_WIDTH, 32, input sample width; fixed at 32.
OUT_WIDTH, 256, output word width; must equal IN_WIDTH*8. Internal RATIO = OUT_WIDTH/IN_WIDTH = 8.
BURST_LEN, 16, number of output words per DDR burst; legal range 2..256.
CNT_WIDTH, 16, width of the emitted-word counter.

Ports:
clk  in  1  single system clock.
rst  in  1  reset; asynchronous, active-high.
s_valid  in  1  input sample valid.
s_ready  out  1  input ready; a transfer occurs when s_valid && s_ready.
s_data  in  32  audio sample.
flush  in  1  single-cycle pulse; pads and emits the current partial word, then closes the burst.
m_valid  out  1  output word valid.
m_ready  in  1  downstream (DDR write FIFO) ready.
m_data  out  256  packed word; sample k of the word occupies bits [32k+31:32k].
m_keep  out  32  byte enables for m_data; bit i covers byte i.
m_last  out  1  marks the last word of a burst.
busy  out  1  block holds data or a pending flush.
word_cnt  out  CNT_WIDTH  count of words accepted downstream (m_valid && m_ready).

Behaviour:
- Reset (async assert, release on clk):
  - m_valid=0, m_data=0, m_keep=0, m_last=0.
  - word_cnt=0, lane=0, burst_cnt=0, flush_pend=0.
  - s_ready=1 after reset; busy=0.
- Storage: pack register (256 bits) with a 3-bit lane pointer, plus a single output register (m_*). There are no other buffers.
- Accept:
  - An accepted sample is written to lane[] and lane increments.
  - At lane==7, the completed word {s_data, pack[223:0]} loads the output register with m_keep=all ones, and lane wraps to 0.
- Output register is "free" when !m_valid || m_ready.
- s_ready = !flush_pend && !(lane==7 && !free).
  - Once the output register is free, the packer resumes without a dead cycle.
- Latency: the eighth sample accepted at cycle N gives m_valid=1 at N+1.
- Sustained throughput is 1 sample/clk while m_ready=1 (1 word per 8 clk).
- Output hold: while m_valid && !m_ready, m_data, m_keep and m_last are stable.
- Burst tracking:
  - burst_cnt increments on each load of the output register.
  - m_last=1 on the load where burst_cnt==BURST_LEN-1, and burst_cnt then returns to 0.
- Flush:
  - A flush pulse sets flush_pend.
  - While flush_pend is set and lane!=0: on the first free cycle, load the output register with the pack register (unused lanes zero), m_keep = low 4*lane bits set, m_last=1. Then lane=0, burst_cnt=0 and flush_pend clears.
  - With lane==0: flush_pend clears on the next cycle, burst_cnt resets to 0 and nothing is emitted.
- Flush in the same cycle as an accepted sample: the sample is included first.
  - If that sample completes lane 7, the full word loads with m_last=1 and burst_cnt=0; no extra word is emitted.
- Flush while flush_pend is already set: merged into the pending flush (no second action).
- word_cnt increments on each m_valid && m_ready and wraps modulo 2^CNT_WIDTH.
- busy = (lane!=0) || m_valid || flush_pend.
- Reset mid-operation:
  - Partial data and the pending word are discarded and all outputs return to their reset values immediately.
  - m_valid drops asynchronously.

Test Plan:
- Samples 0x00000000..0x00000007 with m_ready=1 -> one word, m_data[31:0]=0, m_data[255:224]=7, m_keep=0xFFFFFFFF, m_last=0, m_valid 1 clk after the 8th sample, word_cnt=1.
- 128 consecutive samples with BURST_LEN=16, m_ready=1 -> 16 words, m_last only on word 16, s_ready held at 1 throughout.
- 3 samples then flush -> one word: lanes 0-2 are the data, rest zero, m_keep=0x00000FFF, m_last=1, busy=0 afterwards.
- Hold m_ready=0 after one full word, then feed 8 more samples -> s_ready drops with lane==7 and the 16th sample waiting. Release m_ready: first word accepted, 16th sample accepted the same cycle, second word valid the next cycle.
- Flush coincident with the 8th sample -> exactly one word, m_keep all ones, m_last=1. Flush with lane==0 -> no word emitted, next word starts a new burst.
- Assert rst with 5 samples packed and m_valid=1 -> m_valid=0, word_cnt=0 and busy=0 immediately. After release, 8 new samples produce a word containing only the new data.
